// File: rtl/bmult_sched_pkg.sv
// Shared types and defaults for the shared-multiplier scheduler.
package bmult_sched_pkg;

    localparam int unsigned DEF_W        = 24;
    localparam int unsigned DEF_NREQ     = 4;
    localparam int unsigned DEF_MULT_LAT = 1;

    // Widest requester ID needed for up to 8 requesters.
    localparam int unsigned MAX_IDW      = 3;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        PAUSED = 2'd2
    } sched_state_t;

    // In-flight operation tag carried alongside the datapath.
    typedef struct packed {
        logic               vld;
        logic [MAX_IDW-1:0] id;
    } tag_t;

endpackage

// File: rtl/bmult_share_sched_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            grant_any
);

    int unsigned    sum;
    logic [IDW-1:0] idx;

    // Scan NREQ positions starting at ptr; the first valid one wins.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        sum       = 0;
        idx       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            sum = 32'(ptr) + k;
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end
            idx = IDW'(sum);
            if (en && !grant_any && valid[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = idx;
                grant_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bmult_share_sched.sv
// Round-robin scheduler time-sharing one pipelined multiplier among NREQ requesters.
module bmult_share_sched
    import bmult_sched_pkg::*;
#(
    parameter int unsigned W        = DEF_W,
    parameter int unsigned NREQ     = DEF_NREQ,
    parameter int unsigned MULT_LAT = DEF_MULT_LAT,
    parameter int unsigned IDW      = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              mult_vld,
    output logic [W-1:0]      mult_a,
    output logic [W-1:0]      mult_b,
    input  logic [2*W-1:0]    mult_p,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [2*W-1:0]    rsp_prod,
    input  logic              pause_req,
    output logic              paused,
    output logic              busy
);

    localparam int unsigned CNTW = $clog2(MULT_LAT + 3);

    sched_state_t    state;
    sched_state_t    state_next;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  ptr_next;
    logic [IDW-1:0]  issue_id;
    logic [CNTW-1:0] count;
    logic [CNTW-1:0] count_next;
    tag_t            pipe [MULT_LAT];

    logic            grant_en;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            handshake;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;

    // Grants only while running and not being asked to pause.
    assign grant_en  = (state == RUN) && !pause_req && !rst;
    assign req_ready = grant;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .valid     (req_valid),
        .ptr       (ptr),
        .en        (grant_en),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (handshake)
    );

    // Operand mux driven by the one-hot grant.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*W +: W];
                sel_b = req_b[i*W +: W];
            end
        end
    end

    // Pointer advances past the winner; in-flight count tracks handshakes minus responses.
    always_comb begin
        ptr_next   = ptr;
        count_next = count;
        if (handshake) begin
            ptr_next = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
        end
        if (handshake && !rsp_valid) begin
            count_next = count + CNTW'(1);
        end else if (!handshake && rsp_valid) begin
            count_next = count - CNTW'(1);
        end
    end

    // Next-state logic; DRAIN looks ahead so PAUSED follows the last response immediately.
    always_comb begin
        state_next = state;
        unique case (state)
            RUN: begin
                if (pause_req) state_next = DRAIN;
            end
            DRAIN: begin
                if (!pause_req)             state_next = RUN;
                else if (count_next == '0)  state_next = PAUSED;
            end
            PAUSED: begin
                if (!pause_req) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    // Control registers and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            ptr    <= '0;
            count  <= '0;
            busy   <= 1'b0;
            paused <= 1'b0;
        end else begin
            state  <= state_next;
            ptr    <= ptr_next;
            count  <= count_next;
            busy   <= (count_next != '0);
            paused <= (state_next == PAUSED);
        end
    end

    // Issue stage: operands hold between issues so the datapath inputs stay quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            mult_vld <= 1'b0;
            mult_a   <= '0;
            mult_b   <= '0;
            issue_id <= '0;
        end else begin
            mult_vld <= handshake;
            if (handshake) begin
                mult_a   <= sel_a;
                mult_b   <= sel_b;
                issue_id <= grant_id;
            end
        end
    end

    // Tag pipeline aligned with mult_p; its last stage gates the response register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < MULT_LAT; i++) begin
                pipe[i] <= '0;
            end
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_prod  <= '0;
        end else begin
            pipe[0].vld <= mult_vld;
            pipe[0].id  <= MAX_IDW'(issue_id);
            for (int unsigned i = 1; i < MULT_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
            rsp_valid <= pipe[MULT_LAT-1].vld;
            if (pipe[MULT_LAT-1].vld) begin
                rsp_id   <= IDW'(pipe[MULT_LAT-1].id);
                rsp_prod <= mult_p;
            end
        end
    end

endmodule

// File: tb/tb_bmult_share_sched.sv
// Bench for bmult_share_sched: directed scenarios plus randomized traffic against a queue model.
module tb_bmult_share_sched;

    localparam int unsigned W        = 24;
    localparam int unsigned NREQ     = 4;
    localparam int unsigned MULT_LAT = 1;
    localparam int unsigned IDW      = 2;
    localparam int unsigned PW       = 2 * W;
    localparam int M_RUN    = 0;
    localparam int M_DRAIN  = 1;
    localparam int M_PAUSED = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              mult_vld;
    logic [W-1:0]      mult_a;
    logic [W-1:0]      mult_b;
    logic [PW-1:0]     mult_p;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [PW-1:0]     rsp_prod;
    logic              pause_req;
    logic              paused;
    logic              busy;

    bmult_share_sched #(
        .W        (W),
        .NREQ     (NREQ),
        .MULT_LAT (MULT_LAT),
        .IDW      (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .mult_vld  (mult_vld),
        .mult_a    (mult_a),
        .mult_b    (mult_b),
        .mult_p    (mult_p),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_prod  (rsp_prod),
        .pause_req (pause_req),
        .paused    (paused),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Behavioural datapath: unreset product pipeline of MULT_LAT stages.
    logic [PW-1:0] dp [MULT_LAT];
    always @(posedge clk) begin
        dp[0] <= PW'(mult_a) * PW'(mult_b);
        for (int i = 1; i < int'(MULT_LAT); i++) dp[i] <= dp[i-1];
    end
    assign mult_p = dp[MULT_LAT-1];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int            id;
        logic [PW-1:0] prod;
        longint        due;
    } op_t;

    op_t           q[$];
    longint        cyc = 0;
    bit            armed = 1'b0;
    int            m_ptr = 0;
    int            m_mode = M_RUN;
    int            m_hs = 0;
    int            m_discard = 0;
    int            dut_rsp = 0;
    logic          e_mult_vld = 1'b0;
    logic [W-1:0]  e_mult_a = '0;
    logic [W-1:0]  e_mult_b = '0;
    logic [PW-1:0] e_rsp_prod = '0;
    int            e_rsp_id = 0;

    int              g;
    int              idx;
    logic [NREQ-1:0] exp_ready;
    logic            exp_rv;
    op_t             o;
    op_t             n;

    // Compare every cycle on the falling edge, then advance the model over the next rising edge.
    always @(negedge clk) begin
        g = -1;
        if (armed) begin
            if (!rst && m_mode == M_RUN && !pause_req) begin
                for (int k = 0; k < int'(NREQ); k++) begin
                    idx = (m_ptr + k) % int'(NREQ);
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            check("req_ready", 64'(req_ready), 64'(exp_ready));
            check("mult_vld", 64'(mult_vld), 64'(e_mult_vld));
            check("mult_a", 64'(mult_a), 64'(e_mult_a));
            check("mult_b", 64'(mult_b), 64'(e_mult_b));
            check("busy", 64'(busy), 64'(q.size() != 0));
            check("paused", 64'(paused), 64'(m_mode == M_PAUSED));
            exp_rv = (q.size() > 0) && (q[0].due == cyc);
            if (exp_rv) begin
                o = q.pop_front();
                e_rsp_prod = o.prod;
                e_rsp_id   = o.id;
            end
            check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
            if (exp_rv) check("rsp_id", 64'(rsp_id), 64'(e_rsp_id));
            check("rsp_prod", 64'(rsp_prod), 64'(e_rsp_prod));
            if (rsp_valid) dut_rsp++;
        end
        if (rst) begin
            m_discard += q.size();
            q.delete();
            m_ptr      = 0;
            m_mode     = M_RUN;
            e_mult_vld = 1'b0;
            e_mult_a   = '0;
            e_mult_b   = '0;
            e_rsp_prod = '0;
            e_rsp_id   = 0;
            armed      = 1'b1;
        end else if (armed) begin
            if (g >= 0) begin
                n.id   = g;
                n.prod = PW'(req_a[g*W +: W]) * PW'(req_b[g*W +: W]);
                n.due  = cyc + MULT_LAT + 2;
                q.push_back(n);
                e_mult_a   = req_a[g*W +: W];
                e_mult_b   = req_b[g*W +: W];
                e_mult_vld = 1'b1;
                m_ptr      = (g + 1) % int'(NREQ);
                m_hs++;
            end else begin
                e_mult_vld = 1'b0;
            end
            case (m_mode)
                M_RUN:    if (pause_req) m_mode = M_DRAIN;
                M_DRAIN:  if (!pause_req) m_mode = M_RUN;
                          else if (q.size() == 0) m_mode = M_PAUSED;
                default:  if (!pause_req) m_mode = M_RUN;
            endcase
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_operands();
        for (int i = 0; i < int'(NREQ); i++) begin
            case ($urandom_range(0, 7))
                0:       begin req_a[i*W +: W] = '1; req_b[i*W +: W] = '1; end
                1:       begin req_a[i*W +: W] = '0; req_b[i*W +: W] = W'($urandom); end
                default: begin req_a[i*W +: W] = W'($urandom); req_b[i*W +: W] = W'($urandom); end
            endcase
        end
    endtask

    logic [NREQ-1:0] fair_exp [8];
    logic [NREQ-1:0] alt_exp  [4];
    int hs0;
    int guard;

    initial begin
        fair_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        alt_exp  = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; pause_req = 1'b0;

        // Reset held 20 cycles, then released with no requests.
        repeat (20) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'(0));
        check("rst_mult_vld", 64'(mult_vld), 64'(0));
        check("rst_mult_a", 64'(mult_a), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_prod", 64'(rsp_prod), 64'(0));
        check("rst_paused", 64'(paused), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        repeat (4) next_cycle();

        // Single requester 2 with all-ones operands.
        next_cycle();
        rand_operands();
        req_valid = 4'b0100;
        req_a[2*W +: W] = 24'hFFFFFF;
        req_b[2*W +: W] = 24'hFFFFFF;
        @(negedge clk);
        check("single_grant", 64'(req_ready), 64'(4'b0100));
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        check("single_mult_vld", 64'(mult_vld), 64'(1));
        check("single_mult_a", 64'(mult_a), 64'(24'hFFFFFF));
        next_cycle();
        @(negedge clk);
        check("single_rsp_early", 64'(rsp_valid), 64'(0));
        next_cycle();
        @(negedge clk);
        check("single_rsp_valid", 64'(rsp_valid), 64'(1));
        check("single_rsp_id", 64'(rsp_id), 64'(2));
        check("single_rsp_prod", 64'(rsp_prod), 64'(48'hFFFFFE000001));

        // Bring the pointer back to 0, then all four requesting for 8 cycles.
        next_cycle();
        req_valid = 4'b1000;
        @(negedge clk);
        check("wrap_grant", 64'(req_ready), 64'(4'b1000));
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            rand_operands();
            req_valid = 4'b1111;
            @(negedge clk);
            check("fair_grant", 64'(req_ready), 64'(fair_exp[k]));
        end
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            rand_operands();
            req_valid = 4'b1010;
            @(negedge clk);
            check("alt_grant", 64'(req_ready), 64'(alt_exp[k]));
        end

        // Continuous traffic (grants 0,1,2,3,0), then pause and drain.
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            rand_operands();
            req_valid = 4'b1111;
        end
        next_cycle();
        pause_req = 1'b1;
        @(negedge clk);
        check("pause_no_grant", 64'(req_ready), 64'(0));
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("drain_last_rsp", 64'(rsp_valid), 64'(1));
        check("drain_last_id", 64'(rsp_id), 64'(0));
        check("drain_not_paused", 64'(paused), 64'(0));
        next_cycle();
        @(negedge clk);
        check("paused_set", 64'(paused), 64'(1));
        check("paused_idle", 64'(busy), 64'(0));
        repeat (6) next_cycle();
        next_cycle();
        pause_req = 1'b0;
        @(negedge clk);
        check("resume_wait", 64'(req_ready), 64'(0));
        next_cycle();
        @(negedge clk);
        check("resume_grant", 64'(req_ready), 64'(4'b0010));
        check("resume_paused", 64'(paused), 64'(0));

        // Two more grants, then reset with three operations in flight.
        next_cycle();
        rand_operands();
        next_cycle();
        rand_operands();
        next_cycle();
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        check("pre_rst_busy", 64'(busy), 64'(1));
        check("pre_rst_rsp", 64'(rsp_valid), 64'(1));
        next_cycle();
        rst = 1'b0;
        req_valid = 4'b1111;
        rand_operands();
        @(negedge clk);
        check("post_rst_busy", 64'(busy), 64'(0));
        check("post_rst_rsp", 64'(rsp_valid), 64'(0));
        check("post_rst_ptr", 64'(req_ready), 64'(4'b0001));
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        check("discard_rsp_a", 64'(rsp_valid), 64'(0));
        next_cycle();
        @(negedge clk);
        check("discard_rsp_b", 64'(rsp_valid), 64'(0));

        // Randomized traffic with occasional pause windows.
        hs0 = m_hs;
        guard = 0;
        while ((m_hs - hs0) < 20000 && guard < 80000) begin
            next_cycle();
            rand_operands();
            req_valid = NREQ'($urandom);
            if (pause_req) begin
                if ($urandom_range(0, 7) == 0) pause_req = 1'b0;
            end else if ($urandom_range(0, 99) == 0) begin
                pause_req = 1'b1;
            end
            guard++;
        end
        check("rand_ops_reached", 64'((m_hs - hs0) >= 20000), 64'(1));

        // Drain and confirm every handshake produced exactly one response.
        next_cycle();
        req_valid = '0;
        pause_req = 1'b0;
        repeat (10) next_cycle();
        @(negedge clk);
        #1;
        check("final_busy", 64'(busy), 64'(0));
        check("rsp_total", 64'(dut_rsp), 64'(m_hs - m_discard));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
